// File: rtl/hpu_pkg.sv
// Shared types for the rename checkpoint scheduler, the free-list and the RAT.
package hpu_pkg;

  localparam int CKPT_LEN       = 8;
  localparam int INST_DEC_PARAL = 4;
  localparam int CKPT_IDX_W     = $clog2(CKPT_LEN);

  typedef logic [CKPT_IDX_W-1:0] ckpt_index_t;

  typedef enum logic {
    NORMAL = 1'b0,
    BUBBLE = 1'b1
  } ckpt_ctrl_state_e;

  typedef struct packed {
    logic        en;
    ckpt_index_t index;
  } ckpt_rcov_t;

endpackage

// File: rtl/hpu_ckpt_age_mask.sv
// Combinational age helper: marks live slots younger than i_index and returns
// the number of live slots from i_head up to and including i_index.
module hpu_ckpt_age_mask #(
  parameter int CKPT_LEN = 8
) (
  input  logic [$clog2(CKPT_LEN)-1:0] i_head,
  input  logic [$clog2(CKPT_LEN)-1:0] i_tail,
  input  logic [$clog2(CKPT_LEN)-1:0] i_index,
  input  logic                        i_full,
  output logic [CKPT_LEN-1:0]         o_young_mask,
  output logic [$clog2(CKPT_LEN):0]   o_live_cnt
);

  localparam int IW = $clog2(CKPT_LEN);
  localparam int CW = IW + 1;

  logic [CW-1:0] w_occ;
  logic [IW-1:0] w_idx_age;
  logic [IW-1:0] w_age;

  // head == tail is ambiguous between empty and full, so occupancy needs i_full
  always_comb begin
    w_occ        = i_full ? CW'(CKPT_LEN) : {1'b0, i_tail - i_head};
    w_idx_age    = i_index - i_head;
    w_age        = '0;
    o_young_mask = '0;
    for (int s = 0; s < CKPT_LEN; s++) begin
      w_age           = IW'(s) - i_head;
      o_young_mask[s] = (w_age > w_idx_age) && ({1'b0, w_age} < w_occ);
    end
  end

  assign o_live_cnt = {1'b0, w_idx_age} + CW'(1);

endmodule

// File: rtl/hpu_ren_ckpt_ctrl.sv
// Rename checkpoint scheduler: in-order slot allocation, save/recovery strobes.
// Optional perf counters when HPU_CKPT_PERF_EN is defined.
//   state  | meaning
//   NORMAL | allocation allowed (subject to full/recovery/flush)
//   BUBBLE | allocation blocked for RCOV_BUBBLE cycles after a recovery
module hpu_ren_ckpt_ctrl #(
  parameter int CKPT_LEN       = hpu_pkg::CKPT_LEN,
  parameter int RCOV_BUBBLE    = 1,
  parameter int INST_DEC_PARAL = hpu_pkg::INST_DEC_PARAL
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [INST_DEC_PARAL-1:0]   br_act_id0_i,
  input  logic                        id0_fire_i,
  output logic [$clog2(CKPT_LEN)-1:0] ckpt_index_id0_o,
  output logic [INST_DEC_PARAL-1:0]   ckpt_grant_lane_id0_o,
  output logic                        ckpt_split_o,
  output logic                        ckpt_stall_o,
  output logic                        ckpt_save_en_id1_o,
  output logic [$clog2(CKPT_LEN)-1:0] ckpt_save_index_id1_o,
  input  logic                        br_retire_i,
  input  logic                        rcov_req_i,
  input  logic [$clog2(CKPT_LEN)-1:0] rcov_index_i,
  output logic                        ckpt_rcov_en_o,
  output logic [$clog2(CKPT_LEN)-1:0] ckpt_rcov_index_o,
  input  logic                        flush_i,
  output logic [$clog2(CKPT_LEN):0]   ckpt_cnt_o
`ifdef HPU_CKPT_PERF_EN
  ,
  output logic [31:0]                 prf_ckpt_full_cyc_o,
  output logic [31:0]                 prf_ckpt_split_o
`endif
);

  import hpu_pkg::*;

  localparam int IW = $clog2(CKPT_LEN);
  localparam int CW = IW + 1;
  localparam int LW = INST_DEC_PARAL;

  logic [IW-1:0]       r_head, r_tail;
  logic [CW-1:0]       r_cnt;
  logic [CKPT_LEN-1:0] r_valid;
  ckpt_ctrl_state_e    r_state;
  logic [1:0]          r_bub;
  logic                r_save_en;
  logic [IW-1:0]       r_save_idx;
  ckpt_rcov_t          r_rcov;

  logic [IW-1:0]       w_head_nxt, w_tail_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [CKPT_LEN-1:0] w_valid_nxt;
  ckpt_ctrl_state_e    w_state_nxt;
  logic [1:0]          w_bub_nxt;
  logic                w_save_en_nxt;
  logic [IW-1:0]       w_save_idx_nxt;
  ckpt_rcov_t          w_rcov_nxt;

  logic                w_req, w_full, w_split, w_stall, w_alloc, w_retire;
  logic [CKPT_LEN-1:0] w_young_mask, w_ret_mask, w_alloc_mask;
  logic [CW-1:0]       w_live_cnt;

  assign w_req    = |br_act_id0_i;
  assign w_full   = (r_cnt == CW'(CKPT_LEN));
  assign w_split  = (br_act_id0_i & (br_act_id0_i - LW'(1))) != '0;
  assign w_stall  = w_req & (w_full | (r_state == BUBBLE) | rcov_req_i | flush_i);
  assign w_alloc  = w_req & id0_fire_i & ~w_stall;
  assign w_retire = br_retire_i & (r_cnt != '0);

  assign w_ret_mask   = w_retire ? (CKPT_LEN'(1) << r_head) : '0;
  assign w_alloc_mask = w_alloc  ? (CKPT_LEN'(1) << r_tail) : '0;

  hpu_ckpt_age_mask #(
    .CKPT_LEN (CKPT_LEN)
  ) u_age_mask (
    .i_head       (r_head),
    .i_tail       (r_tail),
    .i_index      (rcov_index_i),
    .i_full       (w_full),
    .o_young_mask (w_young_mask),
    .o_live_cnt   (w_live_cnt)
  );

  // Live count is measured from the pre-retire head; a same-cycle retire removes one more.
  always_comb begin
    w_head_nxt     = r_head;
    w_tail_nxt     = r_tail;
    w_cnt_nxt      = r_cnt;
    w_valid_nxt    = r_valid;
    w_state_nxt    = r_state;
    w_bub_nxt      = r_bub;
    w_save_en_nxt  = 1'b0;
    w_save_idx_nxt = r_tail;
    w_rcov_nxt     = '0;
    if (flush_i) begin
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_cnt_nxt   = '0;
      w_valid_nxt = '0;
      w_state_nxt = NORMAL;
      w_bub_nxt   = '0;
    end else if (rcov_req_i) begin
      w_head_nxt       = r_head + IW'(w_retire);
      w_tail_nxt       = rcov_index_i + IW'(1);
      w_cnt_nxt        = w_live_cnt - CW'(w_retire);
      w_valid_nxt      = r_valid & ~w_young_mask & ~w_ret_mask;
      w_rcov_nxt.en    = 1'b1;
      w_rcov_nxt.index = rcov_index_i;
      if (RCOV_BUBBLE > 0) begin
        w_state_nxt = BUBBLE;
        w_bub_nxt   = 2'(RCOV_BUBBLE - 1);
      end else begin
        w_state_nxt = NORMAL;
        w_bub_nxt   = '0;
      end
    end else begin
      if (r_state == BUBBLE) begin
        if (r_bub == '0) w_state_nxt = NORMAL;
        else             w_bub_nxt   = r_bub - 2'd1;
      end
      w_head_nxt    = r_head + IW'(w_retire);
      w_tail_nxt    = r_tail + IW'(w_alloc);
      w_cnt_nxt     = r_cnt + CW'(w_alloc) - CW'(w_retire);
      w_valid_nxt   = (r_valid & ~w_ret_mask) | w_alloc_mask;
      w_save_en_nxt = w_alloc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
      r_valid    <= '0;
      r_state    <= NORMAL;
      r_bub      <= '0;
      r_save_en  <= 1'b0;
      r_save_idx <= '0;
      r_rcov     <= '0;
    end else begin
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_cnt      <= w_cnt_nxt;
      r_valid    <= w_valid_nxt;
      r_state    <= w_state_nxt;
      r_bub      <= w_bub_nxt;
      r_save_en  <= w_save_en_nxt;
      r_save_idx <= w_save_idx_nxt;
      r_rcov     <= w_rcov_nxt;
    end
  end

`ifdef HPU_CKPT_DEBUG
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(br_retire_i && (r_cnt == '0)));
  end
`endif

`ifdef HPU_CKPT_PERF_EN
  logic [31:0] r_prf_full, r_prf_split;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prf_full  <= '0;
      r_prf_split <= '0;
    end else begin
      if (w_req && w_full && (r_prf_full != '1))
        r_prf_full <= r_prf_full + 32'd1;
      if (w_split && id0_fire_i && (r_prf_split != '1))
        r_prf_split <= r_prf_split + 32'd1;
    end
  end

  assign prf_ckpt_full_cyc_o = r_prf_full;
  assign prf_ckpt_split_o    = r_prf_split;
`endif

  assign ckpt_index_id0_o      = r_tail;
  assign ckpt_grant_lane_id0_o = br_act_id0_i & (~br_act_id0_i + LW'(1));
  assign ckpt_split_o          = w_split;
  assign ckpt_stall_o          = w_stall;
  assign ckpt_save_en_id1_o    = r_save_en;
  assign ckpt_save_index_id1_o = r_save_idx;
  assign ckpt_rcov_en_o        = r_rcov.en;
  assign ckpt_rcov_index_o     = r_rcov.index;
  assign ckpt_cnt_o            = r_cnt;

endmodule

// File: tb/tb_hpu_ren_ckpt_ctrl.sv
// Bench for hpu_ren_ckpt_ctrl: directed scenarios plus random traffic against a
// queue-of-live-slots reference model.
module tb_hpu_ren_ckpt_ctrl;
  import hpu_pkg::*;

  localparam int N  = 8;
  localparam int L  = INST_DEC_PARAL;
  localparam int IW = $clog2(N);
  localparam int RB = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [L-1:0]  br_act;
  logic          fire, retire, rcov, flush;
  logic [IW-1:0] rcov_idx;
  logic [IW-1:0] idx_o, save_idx_o, rcov_idx_o;
  logic [L-1:0]  grant_o;
  logic          split_o, stall_o, save_en_o, rcov_en_o;
  logic [IW:0]   cnt_o;
`ifdef HPU_CKPT_PERF_EN
  logic [31:0]   prf_full_o, prf_split_o;
`endif

  always #5 clk = ~clk;

  hpu_ren_ckpt_ctrl #(.CKPT_LEN(N), .RCOV_BUBBLE(RB), .INST_DEC_PARAL(L)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .br_act_id0_i          (br_act),
    .id0_fire_i            (fire),
    .ckpt_index_id0_o      (idx_o),
    .ckpt_grant_lane_id0_o (grant_o),
    .ckpt_split_o          (split_o),
    .ckpt_stall_o          (stall_o),
    .ckpt_save_en_id1_o    (save_en_o),
    .ckpt_save_index_id1_o (save_idx_o),
    .br_retire_i           (retire),
    .rcov_req_i            (rcov),
    .rcov_index_i          (rcov_idx),
    .ckpt_rcov_en_o        (rcov_en_o),
    .ckpt_rcov_index_o     (rcov_idx_o),
    .flush_i               (flush),
    .ckpt_cnt_o            (cnt_o)
`ifdef HPU_CKPT_PERF_EN
    ,
    .prf_ckpt_full_cyc_o   (prf_full_o),
    .prf_ckpt_split_o      (prf_split_o)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: live slots oldest-first; tail is implied by head + size.
  int q[$];
  int m_head = 0;
  int m_bub  = 0;
  bit e_save_en = 0;
  int e_save_idx = 0;
  bit e_rcov_en = 0;
  int e_rcov_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head = 0; m_bub = 0; e_save_en = 0; e_rcov_en = 0;
  endtask

  task automatic cyc(input logic [L-1:0] br, input logic fi, input logic rt, input logic rc,
                     input logic [IW-1:0] ri, input logic fl, input logic rs);
    int  tail, p;
    bit  req, stall, alloc;
    logic [L-1:0] g;
    @(negedge clk);
    br_act = br; fire = fi; retire = rt; rcov = rc; rcov_idx = ri; flush = fl; rst = rs;
    #1;
    tail  = (m_head + q.size()) % N;
    req   = (br != '0);
    stall = req && (q.size() == N || m_bub > 0 || rc || fl);
    alloc = req && fi && !stall;
    g = '0;
    for (int k = L - 1; k >= 0; k--) if (br[k]) g = L'(1) << k;
    chk("index_id0", 32'(idx_o), tail);
    chk("grant_lane", 32'(grant_o), 32'(g));
    chk("split", 32'(split_o), 32'($countones(br) > 1));
    chk("stall", 32'(stall_o), 32'(stall));
    chk("cnt", 32'(cnt_o), q.size());
    chk("save_en", 32'(save_en_o), 32'(e_save_en));
    if (e_save_en) chk("save_idx", 32'(save_idx_o), e_save_idx);
    chk("rcov_en", 32'(rcov_en_o), 32'(e_rcov_en));
    if (e_rcov_en) chk("rcov_idx", 32'(rcov_idx_o), e_rcov_idx);
    if (rs) begin
      model_reset();
    end else if (fl) begin
      model_reset();
    end else if (rc) begin
      p = 0;
      foreach (q[k]) if (q[k] == int'(ri)) p = k;
      while (q.size() > p + 1) void'(q.pop_back());
      if (rt && q.size() > 0) begin void'(q.pop_front()); m_head = (m_head + 1) % N; end
      e_save_en = 0; e_rcov_en = 1; e_rcov_idx = int'(ri); m_bub = RB;
    end else begin
      if (rt && q.size() > 0) begin void'(q.pop_front()); m_head = (m_head + 1) % N; end
      if (alloc) q.push_back(tail);
      e_save_en = alloc; e_save_idx = tail; e_rcov_en = 0;
      if (m_bub > 0) m_bub--;
    end
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L-1:0]  r_br;
    logic          r_rc;
    logic [IW-1:0] r_ri;
    rst = 1'b1; br_act = '0; fire = 0; retire = 0; rcov = 0; rcov_idx = '0; flush = 0;
    repeat (3) @(posedge clk);
    model_reset();
    cyc('0, 0, 0, 0, '0, 0, 0);

    // fill all eight slots, then a ninth request must stall
    for (int i = 0; i < N; i++) cyc(4'b0001, 1, 0, 0, '0, 0, 0);
    cyc(4'b0001, 1, 0, 0, '0, 0, 0);
    #1;
    chk("full_cnt", 32'(cnt_o), 8);
    chk("ninth_no_save", 32'(save_en_o), 0);

    // full: retire with allocate still stalls; then retire frees slot, alloc wraps to 0
    cyc(4'b0001, 1, 1, 0, '0, 0, 0);
    cyc(4'b0001, 1, 0, 0, '0, 0, 0);
    #1;
    chk("wrap_save_en", 32'(save_en_o), 1);
    chk("wrap_save_idx", 32'(save_idx_o), 0);

    // build head=2 tail=7, recover to slot 4
    cyc('0, 0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 7; i++) cyc(4'b0001, 1, 0, 0, '0, 0, 0);
    cyc('0, 0, 1, 0, '0, 0, 0);
    cyc('0, 0, 1, 0, '0, 0, 0);
    cyc(4'b0001, 1, 0, 1, 3'd4, 0, 0);
    #1;
    chk("rcov_cnt", 32'(cnt_o), 3);
    chk("rcov_en_4", 32'(rcov_en_o), 1);
    chk("rcov_idx_4", 32'(rcov_idx_o), 4);
    cyc(4'b0001, 1, 0, 0, '0, 0, 0);
    cyc(4'b0001, 1, 0, 0, '0, 0, 0);
    #1;
    chk("post_bubble_idx", 32'(save_idx_o), 5);

    // split bundle then the remaining lane
    cyc(4'b0011, 1, 0, 0, '0, 0, 0);
    cyc(4'b0010, 1, 0, 0, '0, 0, 0);

    // recovery and flush together at cnt=5: flush wins
    cyc('0, 0, 1, 0, '0, 0, 0);
    cyc('0, 0, 0, 1, 3'd4, 1, 0);
    #1;
    chk("flush_cnt", 32'(cnt_o), 0);
    chk("flush_no_rcov", 32'(rcov_en_o), 0);
    cyc(4'b0001, 1, 0, 0, '0, 0, 0);

    // head=3 cnt=1: retire and recover the same slot
    for (int i = 0; i < 3; i++) cyc(4'b0001, 1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cyc('0, 0, 1, 0, '0, 0, 0);
    cyc('0, 0, 1, 1, 3'd3, 0, 0);
    #1;
    chk("same_slot_cnt", 32'(cnt_o), 0);
    chk("same_slot_rcov_en", 32'(rcov_en_o), 1);
    chk("same_slot_rcov_idx", 32'(rcov_idx_o), 3);
    chk("same_slot_tail", 32'(idx_o), 4);
    cyc(4'b0001, 1, 0, 0, '0, 0, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      r_br = L'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r_br = '0;
      r_rc = (q.size() > 0) && ($urandom_range(0, 11) == 0);
      r_ri = r_rc ? IW'(q[$urandom_range(0, q.size() - 1)]) : IW'($urandom_range(0, N - 1));
      cyc(r_br, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), r_rc, r_ri,
          1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 199) == 0));
    end

    // reset asserted in the bubble cycle
    cyc('0, 0, 0, 0, '0, 1, 0);
    cyc(4'b0001, 1, 0, 0, '0, 0, 0);
    cyc('0, 0, 0, 1, 3'd0, 0, 0);
    cyc(4'b0001, 1, 0, 0, '0, 0, 1);
    #1;
    chk("rst_cnt", 32'(cnt_o), 0);
    chk("rst_rcov_en", 32'(rcov_en_o), 0);
    cyc(4'b0001, 1, 0, 0, '0, 0, 0);
    cyc('0, 0, 0, 0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hpu_ren_ckpt_ctrl.md
Name: hpu_ren_ckpt_ctrl

Overview:
- Checkpoint scheduler for the rename stage.
- Allocates rename checkpoint slots in order to branches at decode (id0).
- Drives the single save port and the recovery port of the rename free-list and the RAT checkpoints.
- Frees slots when branches retire, and on mispredict or full flush. Stalls decode when no slot is free.

Parameters:
- CKPT_LEN, 8, number of checkpoint slots; power of two, at least 2.
- RCOV_BUBBLE, 1, cycles that allocation stays blocked after a recovery is issued; range 0..3.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- br_act_id0_i  in  INST_DEC_PARAL  per-lane "valid branch needs checkpoint"
- id0_fire_i  in  1  decode bundle advances this cycle
- ckpt_index_id0_o  out  $clog2(CKPT_LEN)  slot assigned to the granted branch
- ckpt_grant_lane_id0_o  out  INST_DEC_PARAL  one-hot lane that receives the slot
- ckpt_split_o  out  1  more than one branch in bundle; only the oldest lane is granted
- ckpt_stall_o  out  1  no slot can be granted this cycle
- ckpt_save_en_id1_o  out  1  save strobe to the free-list/RAT
- ckpt_save_index_id1_o  out  $clog2(CKPT_LEN)  save slot
- br_retire_i  in  1  oldest checkpointed branch retires
- rcov_req_i  in  1  mispredict recovery request
- rcov_index_i  in  $clog2(CKPT_LEN)  checkpoint of the mispredicted branch
- ckpt_rcov_en_o  out  1  recovery strobe to the free-list/RAT
- ckpt_rcov_index_o  out  $clog2(CKPT_LEN)  recovery slot
- flush_i  in  1  full pipeline flush; aligns with afl_rcov
- ckpt_cnt_o  out  $clog2(CKPT_LEN)+1  occupied slots

Behaviour:
- State:
  - head: oldest live slot.
  - tail: next slot to allocate.
  - cnt: occupied slots, 0..CKPT_LEN.
  - valid[CKPT_LEN]: per-slot live bit.
  - FSM: NORMAL / BUBBLE with bubble counter.
- Reset: head=tail=cnt=0, valid=0, FSM=NORMAL. All outputs 0 except ckpt_index_id0_o=0.
- Grant:
  - req = |br_act_id0_i.
  - The granted lane is the lowest set bit of br_act_id0_i.
  - ckpt_split_o = popcount(br_act_id0_i)>1.
  - ckpt_stall_o = req & (cnt==CKPT_LEN | FSM==BUBBLE | rcov_req_i | flush_i).
  - ckpt_index_id0_o = tail (combinational).
- Allocation happens when req & id0_fire_i & !ckpt_stall_o. Then: valid[tail]<=1, tail<=tail+1 (wraps mod CKPT_LEN), cnt+1.
  - Exactly one slot per cycle, even with a split.
  - The next cycle: ckpt_save_en_id1_o=1 and ckpt_save_index_id1_o=the allocated slot (1-cycle registered latency, id1 aligned).
- Retire:
  - br_retire_i with cnt>0: valid[head]<=0, head+1, cnt-1.
  - br_retire_i with cnt==0 is ignored. Debug builds assert on it.
  - Simultaneous allocate and retire: cnt unchanged; both pointers move.
- Recovery (rcov_req_i, rcov_index_i must be valid):
  - Slots strictly younger than rcov_index_i, from rcov_index_i+1 up to tail-1 with wrap, get valid<=0.
  - tail<=rcov_index_i+1. cnt<=live count recomputed from the age distance to head.
  - The recovered slot stays live until its branch retires.
  - Next cycle: ckpt_rcov_en_o=1, ckpt_rcov_index_o=rcov_index_i. FSM enters BUBBLE for RCOV_BUBBLE cycles, or stays NORMAL when RCOV_BUBBLE=0.
  - Allocation in the request cycle is suppressed.
  - A retire in the same cycle applies first (head advances). If the retired slot equals rcov_index_i, cnt becomes 0 and tail=head.
- Flush:
  - head=tail=cnt=0, valid=0, FSM=NORMAL.
  - Any pending save or recovery strobe for the next cycle is cancelled.
  - Priority: flush > rcov > retire/alloc.
- Recovery back-to-back with the bubble: the new request restarts the bubble counter.
- A synchronous reset asserted mid-bubble or mid-recovery returns the block to the reset state on that edge.

Optional Feature:
- HPU_CKPT_PERF_EN defined: adds outputs prf_ckpt_full_cyc_o[31:0] and prf_ckpt_split_o[31:0].
  - These are saturating counts of cycles with req & cnt==CKPT_LEN, and of cycles with ckpt_split_o & id0_fire_i.
  - Both clear on reset.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- hpu_pkg holds:
  - CKPT_LEN and ckpt_index_t.
  - ckpt_ctrl_state_e (NORMAL, BUBBLE).
  - A struct ckpt_rcov_t {en, index} shared with the free-list and RAT.
- One sub-module, hpu_ckpt_age_mask (combinational): from head, tail and index it produces the younger-than mask and the live count. It is used by recovery.

Test Plan (CKPT_LEN=8):
- Allocate 8 single-branch bundles, no retire -> indices 0..7; save strobes 1 cycle later; cnt=8; 9th request gives stall=1, no save.
- Bundle with lanes {1,1} -> grant lane 0, split=1, one save only; next cycle lane 1 is granted the next index.
- Occupied 2..6 (head=2, tail=7); rcov_req index 4 -> valid[5,6]=0, tail=5, cnt=3; rcov_en/index=4 next cycle; 1 bubble cycle stalls allocation.
- cnt=8 with retire and allocate in the same cycle -> stall remains 1, since full is evaluated before retire. Then retire only: cnt=7, next allocation gets index 0 (wrap).
- rcov_req and flush together at cnt=5 -> flush wins: cnt=0, no rcov_en strobe, no bubble.
- Retire of head=3 together with rcov index 3 at cnt=1 -> cnt=0, tail=head=4, rcov_en with index 3 next cycle.
